// File: rtl/piso_25inputs_serializer.sv
// rtl/piso_25inputs_serializer.sv - parallel-in/serial-out serializer for one KERNAL_SIZE x KERNAL_SIZE window
// Optional macro PISO_BACK_TO_BACK_EN: accept the next window on the edge that transfers the last beat.
module piso_25inputs_serializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int KERNAL_SIZE = 5,
   parameter int FIFO_SIZE   = KERNAL_SIZE * KERNAL_SIZE
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [DATA_WIDTH*FIFO_SIZE-1:0] data_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_last,
   output logic [$clog2(FIFO_SIZE)-1:0]    out_index,
   output logic                            busy
);
   localparam int IDX_W = $clog2(FIFO_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_SIZE - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sr_q [FIFO_SIZE];
   logic [DATA_WIDTH-1:0] sr_d [FIFO_SIZE];
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  load_fire;
   logic                  beat_fire;

   assign out_valid = (state_q == SHIFT);
   assign busy      = (state_q == SHIFT);
   assign out_data  = sr_q[0];
   assign out_index = idx_q;
   assign out_last  = (idx_q == LAST_IDX);

`ifdef PISO_BACK_TO_BACK_EN
   assign load_ready = (state_q == IDLE) || (out_valid && out_last && out_ready);
`else
   assign load_ready = (state_q == IDLE);
`endif

   assign load_fire = load_valid && load_ready;
   assign beat_fire = out_valid && out_ready;

   // A load on the last-beat edge overrides the shift, so it is applied after it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      for (int i = 0; i < FIFO_SIZE; i++) begin
         sr_d[i] = sr_q[i];
      end
      if (beat_fire) begin
         for (int i = 0; i < FIFO_SIZE - 1; i++) begin
            sr_d[i] = sr_q[i+1];
         end
         sr_d[FIFO_SIZE-1] = '0;
         if (out_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (load_fire) begin
         for (int i = 0; i < FIFO_SIZE; i++) begin
            sr_d[i] = data_in[DATA_WIDTH*i +: DATA_WIDTH];
         end
         idx_d   = '0;
         state_d = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         for (int i = 0; i < FIFO_SIZE; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int i = 0; i < FIFO_SIZE; i++) begin
            sr_q[i] <= sr_d[i];
         end
      end
   end

endmodule

// File: doc/piso_25inputs_serializer.md
Name: piso_25inputs_serializer

Overview:
- Parallel-in/serial-out counterpart of the 25-tap serial-in weight/window shift FIFO.
- Accepts one full KERNAL_SIZE×KERNAL_SIZE window (25 words) in a single valid/ready transfer.
- Streams the window out one word per accepted beat, element 1 first.
- Feeding this output into a 25-deep serial-in/parallel-out shift register, enabled on each accepted beat, reproduces element k on parallel output k.

Parameters:
- DATA_WIDTH, 32, width of each element.
- KERNAL_SIZE, 5, kernel edge length.
- FIFO_SIZE, KERNAL_SIZE*KERNAL_SIZE, number of elements per window (25 by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  parallel window presented on data_in.
- load_ready  output  1  block can accept a window this cycle.
- data_in  input  DATA_WIDTH*FIFO_SIZE  packed window; element k (1..FIFO_SIZE) occupies bits [DATA_WIDTH*k-1 -: DATA_WIDTH], so element 1 is the LSB slice.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  current element.
- out_last  output  1  current beat is element FIFO_SIZE.
- out_index  output  $clog2(FIFO_SIZE)  zero-based element number of the current beat.
- busy  output  1  window in flight (state SHIFT).

Behaviour:
- Reset: the interface is one clock, with synchronous active-high reset on ports clk/reset. On reset:
  - state=IDLE, shift register all zeros.
  - out_valid=0, out_data=0, out_last=0, out_index=0, busy=0.
  - load_ready=1 from the first cycle after reset deasserts.
- States: IDLE, SHIFT.
- Outputs by state:
  - load_ready is combinational: 1 in IDLE, 0 in SHIFT (except as extended under the optional feature).
  - out_valid=busy=(state==SHIFT).
- Load:
  - Fires when load_valid & load_ready at a clock edge.
  - All FIFO_SIZE elements are captured into the internal shift register (slot 0 = element 1).
  - out_index is cleared to 0 and state goes to SHIFT.
  - Latency: first beat is valid on the cycle after acceptance.
- Output data: out_data=slot 0; out_last=(out_index==FIFO_SIZE-1).
- Beat transfer:
  - Occurs on out_valid & out_ready.
  - Register shifts by one slot toward slot 0; zero enters slot FIFO_SIZE-1; out_index increments.
- Stall: with out_ready=0, out_data, out_index and out_last hold unchanged indefinitely.
- End of window:
  - A transfer with out_last=1 returns state to IDLE, and out_index returns to 0.
  - out_data reads 0 in IDLE, since all slots have shifted to zero.
- Load while busy: load_valid in SHIFT is ignored. data_in is not sampled, and the in-flight window is not disturbed.
- Throughput: one word per cycle when out_ready stays high; exactly FIFO_SIZE beats per window, with no beat dropped or repeated.
- Reset mid-window: the window is discarded. The next cycle shows IDLE reset values and no partial out_last.
- out_valid never deasserts mid-window without reset.

Optional Feature:
- Macro: PISO_BACK_TO_BACK_EN.
- Defined:
  - load_ready is also asserted in SHIFT while out_last & out_ready.
  - A load accepted on the same edge as the last-beat transfer reloads the register, clears out_index and stays in SHIFT.
  - Result: zero idle cycles between consecutive windows.
- Undefined:
  - load_ready only in IDLE.
  - Minimum one-cycle out_valid=0 gap between windows.

Test Plan:
- Basic stream:
  - Stimulus: reset, then load element k = 32'h100+k (k=1..25), with out_ready=1 held.
  - Response: out_data = 0x101..0x119 on 25 consecutive cycles starting 1 cycle after load; out_index = 0..24; out_last only with 0x119; out_valid=0 afterwards.
- Stall:
  - Stimulus: same window; out_ready=0 for 3 cycles while out_index=4.
  - Response: out_data stays 0x105 and out_index stays 4; stream resumes at 0x106 with no loss or duplicate.
- Load while busy:
  - Stimulus: during beat 10, assert load_valid with all elements 32'hDEAD.
  - Response: load_ready=0; remaining beats are 0x10B..0x119; 0xDEAD never appears.
- Reset mid-window:
  - Stimulus: assert reset for 1 cycle at out_index=12.
  - Response: next cycle out_valid=0, out_data=0, out_index=0, load_ready=1; a fresh load restarts at element 1.
- Back-to-back:
  - Stimulus: load_valid held high with two windows, 0x1xx then 0x2xx.
  - Response with PISO_BACK_TO_BACK_EN: 0x201 follows 0x119 on the very next cycle.
  - Response without it: exactly one out_valid=0 cycle between 0x119 and 0x201.
- Round trip:
  - Stimulus: drive out_data into a 25-deep serial-in/parallel-out shift register, enabled on out_valid & out_ready, with random out_ready stalls.
  - Response: after out_last, parallel output k equals 32'h100+k for all k=1..25.
